output_serializer_param: RTL and testbench

//   Parametrised N-channel parallel-to-serial output stage on clk_out16x.

---
 rtl/output_serializer_param.sv | 155 +++++++++++++++
 tb/tb_output_serializer_param.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer_param.sv
// -----------------------------------------------------------------------------
// output_serializer_param
//   N-channel parallel-to-serial output stage. Each channel latches a shared
//   DATA_W-bit word plus a bit count and shifts out exactly that many bits,
//   one per clk_out16x cycle. A one-deep holding buffer per channel lets frames
//   stream back-to-back with no idle cycle between them.
//
// Handshake (load_ch / ch_ready):
//   A load on channel i is taken at a rising edge when load_ch[i]=1 and
//   ch_ready[i]=1. ch_ready depends on registers only (never on load_ch).
//   A load presented while ch_ready[i]=0 is dropped and sets the sticky
//   ovf_err[i]. A zero-length load is taken but produces nothing.
//
// Ports
//   clk_out16x  in   1       serial clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   data_in     in   DATA_W  shared parallel word
//   data_len    in   LEN_W   bits to send (clamped to DATA_W)
//   load_ch     in   NUM_CH  per-channel load strobe
//   flush       in   1       synchronous abort of all channels
//   ch_ready    out  NUM_CH  channel can accept a load this cycle
//   data_out    out  NUM_CH  serial data, 0 when not valid
//   data_vld    out  NUM_CH  serial bit valid (1 = channel in SEND)
//   frame_done  out  NUM_CH  high on the last bit of each frame
//   ovf_err     out  NUM_CH  sticky dropped-load flag
//   any_vld     out  1       OR of data_vld
// -----------------------------------------------------------------------------
module output_serializer_param #(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 128,
  parameter int LEN_W     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_out16x,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [NUM_CH-1:0] load_ch,
  input  logic              flush,
  output logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] data_vld,
  output logic [NUM_CH-1:0] frame_done,
  output logic [NUM_CH-1:0] ovf_err,
  output logic              any_vld
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} st_t;

  localparam logic [LEN_W-1:0] LP_DW = LEN_W'(DATA_W);

  logic [LEN_W-1:0] w_len_eff;
  logic             w_len_zero;

  assign w_len_eff  = (data_len > LP_DW) ? LP_DW : data_len;
  assign w_len_zero = (data_len == '0);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      st_t              r_state;
      logic [DATA_W-1:0] r_shift;
      logic [DATA_W-1:0] r_hold_word;
      logic [LEN_W-1:0]  r_cnt;
      logic [LEN_W-1:0]  r_len;
      logic [LEN_W-1:0]  r_hold_len;
      logic              r_hold_full;
      logic              r_ovf;
      logic [DATA_W-1:0] w_shifted;
      logic              w_bit;
      logic              w_accept;
      logic              w_take;
      logic              w_last;

      assign w_accept = load_ch[g] && !r_hold_full;
      // A zero-length load is accepted but never becomes a frame.
      assign w_take   = w_accept && !w_len_zero;
      assign w_last   = (r_state == ST_SEND) && (r_cnt == r_len);

      if (MSB_FIRST != 0) begin : g_msb
        assign w_shifted = {r_shift[DATA_W-2:0], 1'b0};
        assign w_bit     = r_shift[DATA_W-1];
      end else begin : g_lsb
        assign w_shifted = {1'b0, r_shift[DATA_W-1:1]};
        assign w_bit     = r_shift[0];
      end

      // r_cnt counts the bit currently on data_out, 1..r_len.
      always_ff @(posedge clk_out16x or negedge rst_n) begin
        if (!rst_n) begin
          r_state     <= ST_IDLE;
          r_shift     <= '0;
          r_hold_word <= '0;
          r_cnt       <= '0;
          r_len       <= '0;
          r_hold_len  <= '0;
          r_hold_full <= 1'b0;
          r_ovf       <= 1'b0;
        end else if (flush) begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_hold_full <= 1'b0;
          r_ovf       <= 1'b0;
        end else begin
          if (load_ch[g] && r_hold_full) r_ovf <= 1'b1;
          case (r_state)
            ST_IDLE: begin
              if (w_take) begin
                r_shift <= data_in;
                r_len   <= w_len_eff;
                r_cnt   <= LEN_W'(1);
                r_state <= ST_SEND;
              end
            end
            ST_SEND: begin
              if (w_last) begin
                // Chain the next frame directly so data_vld never dips.
                if (r_hold_full) begin
                  r_shift     <= r_hold_word;
                  r_len       <= r_hold_len;
                  r_cnt       <= LEN_W'(1);
                  r_hold_full <= 1'b0;
                end else if (w_take) begin
                  r_shift <= data_in;
                  r_len   <= w_len_eff;
                  r_cnt   <= LEN_W'(1);
                end else begin
                  r_state <= ST_IDLE;
                end
              end else begin
                r_shift <= w_shifted;
                r_cnt   <= r_cnt + 1'b1;
                if (w_take) begin
                  r_hold_word <= data_in;
                  r_hold_len  <= w_len_eff;
                  r_hold_full <= 1'b1;
                end
              end
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end

      assign ch_ready[g]   = !r_hold_full;
      assign data_vld[g]   = (r_state == ST_SEND);
      assign data_out[g]   = (r_state == ST_SEND) && w_bit;
      assign frame_done[g] = w_last;
      assign ovf_err[g]    = r_ovf;
    end
  endgenerate

  assign any_vld = |data_vld;

endmodule

// File: tb/tb_output_serializer_param.sv
// -----------------------------------------------------------------------------
// tb_output_serializer_param
//   Bench for output_serializer_param. A per-channel queue holds the expected
//   {frame_done, data_out} pair for every serial bit; a negedge monitor pops it
//   whenever data_vld is high. Scenario tasks add timing/flag checks inline.
//   A second small instance (DATA_W=8, MSB_FIRST=0) covers LSB-first order.
// -----------------------------------------------------------------------------
module tb_output_serializer_param;

  localparam int NCH = 8;
  localparam int DW  = 128;
  localparam int LW  = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic [LW-1:0] data_len;
  logic [NCH-1:0] load_ch;
  logic          flush;
  logic [NCH-1:0] ch_ready, data_out, data_vld, frame_done, ovf_err;
  logic          any_vld;

  logic [1:0] lsb_load, lsb_ready, lsb_out, lsb_vld, lsb_done, lsb_ovf;
  logic       lsb_any;

  int checks;
  int errors;

  logic [1:0] exp_q [NCH][$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  output_serializer_param #(
    .NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .MSB_FIRST(1)
  ) u_dut (
    .clk_out16x(clk), .rst_n(rst_n), .data_in(data_in), .data_len(data_len),
    .load_ch(load_ch), .flush(flush), .ch_ready(ch_ready), .data_out(data_out),
    .data_vld(data_vld), .frame_done(frame_done), .ovf_err(ovf_err),
    .any_vld(any_vld)
  );

  output_serializer_param #(
    .NUM_CH(2), .DATA_W(8), .LEN_W(4), .MSB_FIRST(0)
  ) u_lsb (
    .clk_out16x(clk), .rst_n(rst_n), .data_in(data_in[7:0]),
    .data_len(data_len[3:0]), .load_ch(lsb_load), .flush(flush),
    .ch_ready(lsb_ready), .data_out(lsb_out), .data_vld(lsb_vld),
    .frame_done(lsb_done), .ovf_err(lsb_ovf), .any_vld(lsb_any)
  );

  // scoreboard monitor
  always @(negedge clk) begin
    logic [1:0] e;
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (data_vld[ch] === 1'b1) begin
        if (exp_q[ch].size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected_vld ch=%0d got vld=1 exp vld=0 t=%0t", ch, $time);
        end else begin
          e = exp_q[ch].pop_front();
          if ({frame_done[ch], data_out[ch]} !== e) begin
            errors++;
            $display("FAIL mon_bit ch=%0d got done/out=%b%b exp %b t=%0t",
                     ch, frame_done[ch], data_out[ch], e, $time);
          end
        end
      end else if (data_out[ch] !== 1'b0 || frame_done[ch] !== 1'b0) begin
        errors++;
        $display("FAIL mon_idle ch=%0d got out=%b done=%b exp 0/0 t=%0t",
                 ch, data_out[ch], frame_done[ch], $time);
      end
    end
    checks++;
    if (any_vld !== (|data_vld)) begin
      errors++;
      $display("FAIL mon_any_vld got %b exp %b vld=%b", any_vld, |data_vld, data_vld);
    end
  end

  // driver helpers
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input int ch, input logic [DW-1:0] d, input int len);
    int leff;
    leff = (len > DW) ? DW : len;
    for (int k = 0; k < leff; k++)
      exp_q[ch].push_back({(k == leff - 1) ? 1'b1 : 1'b0, d[DW-1-k]});
  endtask

  task automatic clear_queues;
    for (int ch = 0; ch < NCH; ch++) exp_q[ch].delete();
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // scenarios
  task automatic test_reset;
    rst_n = 1'b0; data_in = '0; data_len = '0; load_ch = '0; flush = 1'b0;
    lsb_load = '0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if (ch_ready !== 8'hFF) begin errors++; $display("FAIL reset_ready got %h exp ff", ch_ready); end
    checks++;
    if (data_vld !== 8'h00) begin errors++; $display("FAIL reset_vld got %h exp 00", data_vld); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", data_out); end
    checks++;
    if (frame_done !== 8'h00) begin errors++; $display("FAIL reset_done got %h exp 00", frame_done); end
    checks++;
    if (ovf_err !== 8'h00) begin errors++; $display("FAIL reset_ovf got %h exp 00", ovf_err); end
    checks++;
    if (any_vld !== 1'b0) begin errors++; $display("FAIL reset_any got %b exp 0", any_vld); end
  endtask

  task automatic test_long_frame;
    logic [DW-1:0] d;
    int nv, first, last, nd, dc;
    d = '0; d[DW-1] = 1'b1; d[0] = 1'b1;
    data_in = d; data_len = 16'd128; load_ch = 8'h01;
    push_frame(0, d, 128);
    tick;
    load_ch = '0;
    nv = 0; first = 0; last = 0; nd = 0; dc = 0;
    for (int c = 1; c <= 132; c++) begin
      if (data_vld[0]) begin nv++; if (first == 0) first = c; last = c; end
      if (frame_done[0]) begin nd++; dc = c; end
      tick;
    end
    checks++;
    if (nv != 128 || first != 1 || last != 128) begin
      errors++;
      $display("FAIL long_vld_window got n=%0d first=%0d last=%0d exp 128/1/128", nv, first, last);
    end
    checks++;
    if (nd != 1 || dc != 128) begin
      errors++;
      $display("FAIL long_done got count=%0d cycle=%0d exp 1/128", nd, dc);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d1, d2;
    d1 = rand_word(); d1[DW-1 -: 4] = 4'b1011;
    d2 = rand_word(); d2[DW-1 -: 4] = 4'b0110;
    data_in = d1; data_len = 16'd4; load_ch = 8'h08;
    push_frame(3, d1, 4);
    tick;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (ch_ready[3] !== ((c >= 2 && c <= 4) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL b2b_ready c=%0d got %b", c, ch_ready[3]);
      end
      checks++;
      if (data_vld[3] !== ((c <= 8) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL b2b_vld c=%0d got %b", c, data_vld[3]);
      end
      checks++;
      if (frame_done[3] !== ((c == 4 || c == 8) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL b2b_done c=%0d got %b", c, frame_done[3]);
      end
      if (c == 1) begin
        data_in = d2; load_ch = 8'h08;
        push_frame(3, d2, 4);
      end else begin
        load_ch = '0;
      end
      tick;
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] da, db, dc;
    da = rand_word(); db = rand_word(); dc = rand_word();
    data_in = da; data_len = 16'd3; load_ch = 8'h20;
    push_frame(5, da, 3);
    tick;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) begin
        checks++;
        if (ch_ready[5] !== 1'b0) begin errors++; $display("FAIL ovf_ready_drop got %b exp 0", ch_ready[5]); end
      end
      checks++;
      if (data_vld[5] !== ((c <= 6) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL ovf_vld c=%0d got %b", c, data_vld[5]);
      end
      checks++;
      if (ovf_err[5] !== ((c >= 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL ovf_flag c=%0d got %b", c, ovf_err[5]);
      end
      if (c == 1) begin
        data_in = db; load_ch = 8'h20; push_frame(5, db, 3);
      end else if (c == 2) begin
        data_in = dc; load_ch = 8'h20;
      end else begin
        load_ch = '0;
      end
      tick;
    end
    checks++;
    if (ovf_err !== 8'h20) begin errors++; $display("FAIL ovf_only_ch5 got %h exp 20", ovf_err); end
  endtask

  task automatic test_edge_len;
    logic [DW-1:0] d;
    int nv, nd;
    logic [1:0] lsb_exp [5];
    // len = 0
    d = rand_word(); data_in = d; data_len = 16'd0; load_ch = 8'h02;
    tick;
    load_ch = '0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (data_vld[1] !== 1'b0 || frame_done[1] !== 1'b0 || ovf_err[1] !== 1'b0 || ch_ready[1] !== 1'b1) begin
        errors++;
        $display("FAIL len0 c=%0d got vld=%b done=%b ovf=%b rdy=%b exp 0/0/0/1",
                 c, data_vld[1], frame_done[1], ovf_err[1], ch_ready[1]);
      end
      tick;
    end
    // len = 200 clamps to 128
    d = rand_word(); data_in = d; data_len = 16'd200; load_ch = 8'h04;
    push_frame(2, d, 200);
    tick;
    load_ch = '0; nv = 0; nd = 0;
    for (int c = 1; c <= 135; c++) begin
      if (data_vld[2]) nv++;
      if (frame_done[2]) nd++;
      tick;
    end
    checks++;
    if (nv != 128 || nd != 1) begin
      errors++; $display("FAIL len200 got bits=%0d done=%0d exp 128/1", nv, nd);
    end
    // len = 1
    d = rand_word(); data_in = d; data_len = 16'd1; load_ch = 8'h10;
    push_frame(4, d, 1);
    tick;
    load_ch = '0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (data_vld[4] !== ((c == 1) ? 1'b1 : 1'b0) || frame_done[4] !== ((c == 1) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL len1 c=%0d got vld=%b done=%b", c, data_vld[4], frame_done[4]);
      end
      tick;
    end
    // LSB-first: 8'hB2 len 5 -> bits 0,1,0,0,1
    lsb_exp[0] = 2'b00; lsb_exp[1] = 2'b01; lsb_exp[2] = 2'b00;
    lsb_exp[3] = 2'b00; lsb_exp[4] = 2'b11;
    data_in = '0; data_in[7:0] = 8'hB2; data_len = 16'd5; lsb_load = 2'b01;
    tick;
    lsb_load = '0;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (c <= 5) begin
        if (lsb_vld[0] !== 1'b1 || {lsb_done[0], lsb_out[0]} !== lsb_exp[c-1]) begin
          errors++;
          $display("FAIL lsb_order c=%0d got vld=%b done/out=%b%b exp 1 %b",
                   c, lsb_vld[0], lsb_done[0], lsb_out[0], lsb_exp[c-1]);
        end
      end else if (lsb_vld[0] !== 1'b0) begin
        errors++; $display("FAIL lsb_order_end got vld=%b exp 0", lsb_vld[0]);
      end
      tick;
    end
    // LSB-first data=1 len=1 -> out=1
    data_in = '0; data_in[0] = 1'b1; data_len = 16'd1; lsb_load = 2'b10;
    tick;
    lsb_load = '0;
    checks++;
    if (lsb_vld[1] !== 1'b1 || lsb_out[1] !== 1'b1 || lsb_done[1] !== 1'b1) begin
      errors++;
      $display("FAIL lsb_len1 got vld=%b out=%b done=%b exp 1/1/1", lsb_vld[1], lsb_out[1], lsb_done[1]);
    end
    tick;
    checks++;
    if (lsb_vld[1] !== 1'b0) begin errors++; $display("FAIL lsb_len1_end got vld=%b exp 0", lsb_vld[1]); end
  endtask

  task automatic test_flush;
    logic [DW-1:0] d, d2;
    d = rand_word(); d2 = rand_word();
    data_in = d; data_len = 16'd60; load_ch = 8'hFF;
    for (int ch = 0; ch < NCH; ch++) push_frame(ch, d, 60);
    tick;
    data_in = d2; data_len = 16'd9; load_ch = 8'h80;
    push_frame(7, d2, 9);
    tick;
    load_ch = 8'h80;
    tick;
    load_ch = '0;
    repeat (2) tick;
    checks++;
    if (data_vld !== 8'hFF || ovf_err[7] !== 1'b1) begin
      errors++; $display("FAIL flush_pre got vld=%h ovf7=%b exp ff/1", data_vld, ovf_err[7]);
    end
    flush = 1'b1; load_ch = 8'hFF; data_in = rand_word(); data_len = 16'd20;
    clear_queues();
    tick;
    flush = 1'b0; load_ch = '0;
    checks++;
    if (data_vld !== 8'h00 || data_out !== 8'h00 || frame_done !== 8'h00) begin
      errors++;
      $display("FAIL flush_outputs got vld=%h out=%h done=%h exp 00", data_vld, data_out, frame_done);
    end
    checks++;
    if (ovf_err !== 8'h00) begin errors++; $display("FAIL flush_ovf got %h exp 00", ovf_err); end
    checks++;
    if (ch_ready !== 8'hFF) begin errors++; $display("FAIL flush_ready got %h exp ff", ch_ready); end
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (data_vld !== 8'h00) begin errors++; $display("FAIL flush_discard c=%0d got vld=%h exp 00", c, data_vld); end
      tick;
    end
  endtask

  task automatic test_async_reset;
    logic [DW-1:0] d;
    d = rand_word(); data_in = d; data_len = 16'd100; load_ch = 8'h01;
    push_frame(0, d, 100);
    tick;
    load_ch = '0;
    repeat (10) tick;
    checks++;
    if (data_vld[0] !== 1'b1) begin errors++; $display("FAIL arst_pre got vld=%b exp 1", data_vld[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_vld !== 8'h00 || data_out !== 8'h00 || frame_done !== 8'h00 || any_vld !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs got vld=%h out=%h done=%h any=%b exp 0", data_vld, data_out, frame_done, any_vld);
    end
    checks++;
    if (ovf_err !== 8'h00 || ch_ready !== 8'hFF) begin
      errors++; $display("FAIL arst_flags got ovf=%h rdy=%h exp 00/ff", ovf_err, ch_ready);
    end
    clear_queues();
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (2) tick;
    checks++;
    if (ch_ready !== 8'hFF || data_vld !== 8'h00) begin
      errors++; $display("FAIL arst_release got rdy=%h vld=%h exp ff/00", ch_ready, data_vld);
    end
  endtask

  // sequence and report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_long_frame();
    test_back_to_back();
    test_overflow();
    test_edge_len();
    test_flush();
    test_async_reset();
    repeat (3) tick;
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (exp_q[ch].size() != 0) begin
        errors++;
        $display("FAIL leftover_bits ch=%0d got %0d pending exp 0", ch, exp_q[ch].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
